// File: rtl/bw_io_ddr_clk_ctl.sv
// -----------------------------------------------------------------------------
// bw_io_ddr_clk_ctl
//
// Sequencer in front of the DDR clock pad pair. It owns the pad clock enable
// and the pull-up / pull-down impedance drive codes (cbu / cbd).
//
//   * Clock enable: a wake delay of ON_DLY cycles passes between an accepted
//     request and the DRAM clocks starting. A drain delay of OFF_DLY cycles
//     passes between the request dropping and the clocks stopping. A request
//     that returns during the drain resumes ON with no gap in the clock.
//   * Drive codes: with the clocks stopped (OFF / WAKE), a new code loads
//     directly. With the clocks running (ON / SLEEP), each code walks toward
//     its target one LSB every STEP_CYC cycles, so the running pads never see
//     a large impedance jump.
//
// Handshake: code_vld is a single-cycle strobe with no back-pressure. Every
// strobe captures cbu_tgt/cbd_tgt into the target registers, and a later
// strobe simply overwrites them. code_busy reports that the applied codes
// have not yet reached the targets.
//
// Ports
//   rclk                in   core clock
//   rst_l               in   synchronous reset, active low
//   clk_en_req          in   level request for running DRAM clocks
//   code_vld            in   strobe: cbu_tgt / cbd_tgt valid this cycle
//   cbu_tgt             in   target pull-up code   [CODE_W-1:0]
//   cbd_tgt             in   target pull-down code [CODE_W-1:0]
//   dram_io_clk_enable  out  pad pair clock enable (registered)
//   cbu                 out  applied pull-up code   (registered)
//   cbd                 out  applied pull-down code (registered)
//   code_busy           out  applied codes differ from targets (registered)
//   clk_on              out  1 only while in state ON (registered)
// -----------------------------------------------------------------------------
module bw_io_ddr_clk_ctl #(
    parameter int                 CODE_W   = 8,
    parameter int                 ON_DLY   = 16,
    parameter int                 OFF_DLY  = 8,
    parameter int                 STEP_CYC = 4,
    parameter logic [CODE_W-1:0]  RST_CODE = 8'h40
) (
    input  logic              rclk,
    input  logic              rst_l,
    input  logic              clk_en_req,
    input  logic              code_vld,
    input  logic [CODE_W-1:0] cbu_tgt,
    input  logic [CODE_W-1:0] cbd_tgt,
    output logic              dram_io_clk_enable,
    output logic [CODE_W-1:0] cbu,
    output logic [CODE_W-1:0] cbd,
    output logic              code_busy,
    output logic              clk_on
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    localparam int DLY_MAX = (ON_DLY > OFF_DLY) ? ON_DLY : OFF_DLY;
    localparam int CNT_W   = $clog2(DLY_MAX + 1);
    localparam int STEP_W  = $clog2(STEP_CYC + 1);

    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_DLY - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_DLY - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_SLEEP = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;

    logic [CODE_W-1:0]   cbu_tgt_reg;
    logic [CODE_W-1:0]   cbd_tgt_reg;
    logic [CODE_W-1:0]   cbu_tgt_nxt;
    logic [CODE_W-1:0]   cbd_tgt_nxt;
    logic [CODE_W-1:0]   cbu_nxt;
    logic [CODE_W-1:0]   cbd_nxt;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   step_cnt_nxt;

    logic                slewing;
    logic                code_mismatch;

    // One LSB toward the target. Because the move is always toward an
    // in-range target, the result can never wrap past 0 or the maximum code.
    function automatic logic [CODE_W-1:0] step_toward(
        input logic [CODE_W-1:0] cur,
        input logic [CODE_W-1:0] tgt
    );
        logic [CODE_W-1:0] res;
        res = cur;
        if (cur < tgt) begin
            res = cur + CODE_W'(1);
        end else if (cur > tgt) begin
            res = cur - CODE_W'(1);
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Clock enable FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_OFF: begin
                cnt_nxt = '0;
                if (clk_en_req) begin
                    state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                // Any drop of the request abandons the wake; the next
                // request starts the full delay from zero.
                if (!clk_en_req) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else if (cnt == ON_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_ON: begin
                cnt_nxt = '0;
                if (!clk_en_req) begin
                    state_nxt = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                // Enable is still high here, so returning to ON leaves the
                // pad clock running without a gap.
                if (clk_en_req) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else if (cnt == OFF_LAST) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Drive code next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        cbu_tgt_nxt   = code_vld ? cbu_tgt : cbu_tgt_reg;
        cbd_tgt_nxt   = code_vld ? cbd_tgt : cbd_tgt_reg;
        cbu_nxt       = cbu;
        cbd_nxt       = cbd;
        step_cnt_nxt  = '0;
        slewing       = (state == ST_ON) || (state == ST_SLEEP);
        code_mismatch = (cbu != cbu_tgt_reg) || (cbd != cbd_tgt_reg);

        if (!slewing) begin
            // Clocks stopped: apply the newest target at once. This also
            // finishes any slew left incomplete when the clocks stopped.
            cbu_nxt = cbu_tgt_nxt;
            cbd_nxt = cbd_tgt_nxt;
        end else if (code_mismatch) begin
            // Step pacing runs off the registered targets; a retarget only
            // changes the direction, not the pacing phase.
            if (step_cnt == STEP_LAST) begin
                cbu_nxt = step_toward(cbu, cbu_tgt_reg);
                cbd_nxt = step_toward(cbd, cbd_tgt_reg);
            end else begin
                step_cnt_nxt = step_cnt + STEP_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            state              <= ST_OFF;
            cnt                <= '0;
            step_cnt           <= '0;
            cbu_tgt_reg        <= RST_CODE;
            cbd_tgt_reg        <= RST_CODE;
            cbu                <= RST_CODE;
            cbd                <= RST_CODE;
            code_busy          <= 1'b0;
            dram_io_clk_enable <= 1'b0;
            clk_on             <= 1'b0;
        end else begin
            state              <= state_nxt;
            cnt                <= cnt_nxt;
            step_cnt           <= step_cnt_nxt;
            cbu_tgt_reg        <= cbu_tgt_nxt;
            cbd_tgt_reg        <= cbd_tgt_nxt;
            cbu                <= cbu_nxt;
            cbd                <= cbd_nxt;
            // Outputs are computed from next-state values so each one lines
            // up with the state/code it describes.
            code_busy          <= (cbu_nxt != cbu_tgt_nxt) ||
                                  (cbd_nxt != cbd_tgt_nxt);
            dram_io_clk_enable <= (state_nxt == ST_ON) ||
                                  (state_nxt == ST_SLEEP);
            clk_on             <= (state_nxt == ST_ON);
        end
    end

endmodule

// File: tb/tb_bw_io_ddr_clk_ctl.sv
// -----------------------------------------------------------------------------
// Directed bench for bw_io_ddr_clk_ctl (default parameters: ON_DLY=16,
// OFF_DLY=8, STEP_CYC=4, RST_CODE=8'h40). Inputs change 1 time unit after
// the rising edge; outputs are checked at that same point, i.e. they show
// the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_bw_io_ddr_clk_ctl;

    logic       rclk;
    logic       rst_l;
    logic       clk_en_req;
    logic       code_vld;
    logic [7:0] cbu_tgt;
    logic [7:0] cbd_tgt;
    logic       dram_io_clk_enable;
    logic [7:0] cbu;
    logic [7:0] cbd;
    logic       code_busy;
    logic       clk_on;

    int vectors;
    int miscompares;

    bw_io_ddr_clk_ctl dut (
        .rclk               (rclk),
        .rst_l              (rst_l),
        .clk_en_req         (clk_en_req),
        .code_vld           (code_vld),
        .cbu_tgt            (cbu_tgt),
        .cbd_tgt            (cbd_tgt),
        .dram_io_clk_enable (dram_io_clk_enable),
        .cbu                (cbu),
        .cbd                (cbd),
        .code_busy          (code_busy),
        .clk_on             (clk_on)
    );

    // clock
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},   32'(dram_io_clk_enable), 32'h0);
        chk({tag, "_on"},   32'(clk_on),             32'h0);
        chk({tag, "_busy"}, 32'(code_busy),          32'h0);
        chk({tag, "_cbu"},  32'(cbu),                32'h40);
        chk({tag, "_cbd"},  32'(cbd),                32'h40);
    endtask

    // Request is high in the current cycle: enable low for 16 cycles,
    // then high together with clk_on.
    task automatic wake_seq(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk({tag, "_wait_en"}, 32'(dram_io_clk_enable), 32'h0);
        end
        tick();
        chk({tag, "_en"}, 32'(dram_io_clk_enable), 32'h1);
        chk({tag, "_on"}, 32'(clk_on), 32'h1);
    endtask

    task automatic strobe(input logic [7:0] u, input logic [7:0] d);
        code_vld = 1'b1;
        cbu_tgt  = u;
        cbd_tgt  = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_l       = 1'b0;
        clk_en_req  = 1'b0;
        code_vld    = 1'b0;
        cbu_tgt     = 8'h00;
        cbd_tgt     = 8'h00;

        // reset
        tick();
        tick();
        chk_reset_vals("reset");

        // wake from reset: req high in cycle 0
        rst_l      = 1'b1;
        clk_en_req = 1'b1;
        wake_seq("wake0");

        // drain then rearm: req low 3 cycles, enable never drops
        clk_en_req = 1'b0;
        tick();
        chk("sleep_en", 32'(dram_io_clk_enable), 32'h1);
        chk("sleep_on", 32'(clk_on), 32'h0);
        tick();
        chk("sleep_en2", 32'(dram_io_clk_enable), 32'h1);
        tick();
        chk("sleep_en3", 32'(dram_io_clk_enable), 32'h1);
        clk_en_req = 1'b1;
        tick();
        chk("rearm_en", 32'(dram_io_clk_enable), 32'h1);
        chk("rearm_on", 32'(clk_on), 32'h1);

        // drain fully: enable low 9 cycles after the drop
        clk_en_req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("drain_en", 32'(dram_io_clk_enable), 32'h1);
        end
        tick();
        chk("drain_off", 32'(dram_io_clk_enable), 32'h0);
        chk("drain_on", 32'(clk_on), 32'h0);

        // wake abort: req high 5 cycles then low; enable never rises
        clk_en_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("abort_en", 32'(dram_io_clk_enable), 32'h0);
        end
        clk_en_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("abort_idle_en", 32'(dram_io_clk_enable), 32'h0);
        end

        // direct load while clocks are off
        strobe(8'h55, 8'h22);
        tick();
        code_vld = 1'b0;
        chk("direct_cbu",  32'(cbu), 32'h55);
        chk("direct_cbd",  32'(cbd), 32'h22);
        chk("direct_busy", 32'(code_busy), 32'h0);

        // restore codes in the same cycle as OFF->WAKE: still a direct load,
        // and the wake after the abort takes the full delay
        strobe(8'h40, 8'h40);
        clk_en_req = 1'b1;
        tick();
        code_vld = 1'b0;
        chk("wakeload_cbu",  32'(cbu), 32'h40);
        chk("wakeload_cbd",  32'(cbd), 32'h40);
        chk("wakeload_busy", 32'(code_busy), 32'h0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("rewake_wait_en", 32'(dram_io_clk_enable), 32'h0);
        end
        tick();
        chk("rewake_en", 32'(dram_io_clk_enable), 32'h1);

        // slew up 40 -> 43 while ON: steps land at +5, +9, +13
        strobe(8'h43, 8'h40);
        for (int i = 1; i <= 13; i++) begin
            tick();
            code_vld = 1'b0;
            chk("slew_cbu",  32'(cbu), 32'h40 + 32'((i - 1) / 4));
            chk("slew_cbd",  32'(cbd), 32'h40);
            chk("slew_busy", 32'(code_busy), (i < 13) ? 32'h1 : 32'h0);
        end

        // retarget mid-slew: up toward 45, then back to 43; cbd walks down
        strobe(8'h45, 8'h3e);
        for (int i = 1; i <= 5; i++) begin
            tick();
            code_vld = 1'b0;
        end
        chk("rt_up_cbu", 32'(cbu), 32'h44);
        chk("rt_up_cbd", 32'(cbd), 32'h3f);
        tick();
        strobe(8'h43, 8'h3e);
        tick();
        code_vld = 1'b0;
        chk("rt_hold_cbu",  32'(cbu), 32'h44);
        chk("rt_hold_busy", 32'(code_busy), 32'h1);
        tick();
        chk("rt_hold2_cbu", 32'(cbu), 32'h44);
        tick();
        chk("rt_back_cbu",  32'(cbu), 32'h43);
        chk("rt_back_cbd",  32'(cbd), 32'h3e);
        chk("rt_back_busy", 32'(code_busy), 32'h0);

        // slew during drain; remaining distance loads directly once OFF
        strobe(8'h50, 8'h3e);
        clk_en_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            code_vld = 1'b0;
        end
        chk("drain_slew_cbu", 32'(cbu), 32'h44);
        for (int i = 6; i <= 9; i++) begin
            tick();
        end
        chk("drain_slew_cbu2", 32'(cbu), 32'h45);
        chk("drain_slew_en",   32'(dram_io_clk_enable), 32'h0);
        chk("drain_slew_busy", 32'(code_busy), 32'h1);
        tick();
        chk("off_load_cbu",  32'(cbu), 32'h50);
        chk("off_load_busy", 32'(code_busy), 32'h0);

        // reset in the middle of WAKE
        clk_en_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
        end
        rst_l = 1'b0;
        tick();
        chk_reset_vals("rst_wake");

        // wake again, then reset in the middle of a slew
        rst_l = 1'b1;
        wake_seq("wake2");
        strobe(8'h48, 8'h38);
        for (int i = 1; i <= 6; i++) begin
            tick();
            code_vld = 1'b0;
        end
        chk("pre_rst_cbu",  32'(cbu), 32'h41);
        chk("pre_rst_busy", 32'(code_busy), 32'h1);
        rst_l = 1'b0;
        tick();
        chk_reset_vals("rst_slew");

        // state is OFF after reset: a request takes the full wake delay
        rst_l = 1'b1;
        wake_seq("wake3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // runaway guard
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
